// File: rtl/k_digitrev_sink.sv
// k_digitrev_sink: accepts digit-reversed FFT result frames into a ping-pong
// pair of banks and re-emits each frame in natural bin order.
// Framing is driven by the sample counter; tlast only raises events.
module k_digitrev_sink #(
  parameter int TRANSFORM_LENGTH = 16,
  parameter int DATA_WIDTH       = 16,
  localparam int L               = $clog2(TRANSFORM_LENGTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  input  logic                  s_axis_data_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic [L-1:0]          m_axis_data_tuser,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic                  m_axis_data_tlast,
  output logic                  event_tlast_unexpected,
  output logic                  event_tlast_missing
);

  localparam logic [L-1:0] LAST = L'(TRANSFORM_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} rd_state_t;

  // Reverse the base-4 digits of a bin index.
  function automatic logic [L-1:0] digitrev4(input logic [L-1:0] v);
    logic [L-1:0] r;
    r = '0;
    for (int i = 0; i < L / 2; i++) begin
      r[2*i +: 2] = v[L-2-2*i +: 2];
    end
    return r;
  endfunction

  // Both banks live in one array; the bank bit is the address MSB.
  logic [DATA_WIDTH-1:0] mem [0:2*TRANSFORM_LENGTH-1];

  logic [L-1:0]          wcnt;
  logic                  wbank;
  logic                  rbank;
  logic [1:0]            full;
  logic [L-1:0]          rcnt;
  rd_state_t             state;

  logic                  sp_valid;
  logic [DATA_WIDTH-1:0] sp_data;
  logic [L-1:0]          sp_user;
  logic                  sp_last;

  logic                  in_hs;
  logic                  close_bank;
  logic                  pop;
  logic [1:0]            occ_next;
  logic                  room;
  logic                  ren;
  logic                  rd_bank;
  logic [L-1:0]          rd_addr;
  logic                  rd_last;
  logic                  free_bank;
  logic [DATA_WIDTH-1:0] rd_word;

  assign s_axis_data_tready = !full[wbank];
  assign in_hs      = s_axis_data_tvalid && s_axis_data_tready;
  assign close_bank = in_hs && (wcnt == LAST);
  assign pop        = m_axis_data_tvalid && m_axis_data_tready;
  // Occupancy of the two-entry output buffer once this cycle's pop is taken.
  assign occ_next   = 2'(m_axis_data_tvalid) + 2'(sp_valid) - 2'(pop);
  assign room       = (occ_next <= 2'd1);
  assign rd_word    = mem[{rd_bank, rd_addr}];
  assign rd_last    = (rd_addr == LAST);

  // Read-issue decode: which bank/address is read this cycle and whether a bank is released.
  always_comb begin
    ren       = 1'b0;
    rd_bank   = rbank;
    rd_addr   = rcnt;
    free_bank = 1'b0;
    case (state)
      IDLE: begin
        ren = 1'b0;
      end
      STREAM: begin
        ren = room;
      end
      DRAIN: begin
        if (pop && m_axis_data_tlast) begin
          free_bank = 1'b1;
          if (full[~rbank]) begin
            ren     = 1'b1;
            rd_bank = ~rbank;
            rd_addr = '0;
          end else begin
            ren = 1'b0;
          end
        end else begin
          free_bank = 1'b0;
        end
      end
      default: begin
        ren = 1'b0;
      end
    endcase
  end

  // Sample storage: scatter each accepted sample to its digit-reversed slot.
  always_ff @(posedge aclk) begin
    if (in_hs) begin
      mem[{wbank, digitrev4(wcnt)}] <= s_axis_data_tdata;
    end
  end

  // Write counter, write-bank pointer and tlast framing events.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wcnt                   <= '0;
      wbank                  <= 1'b0;
      event_tlast_unexpected <= 1'b0;
      event_tlast_missing    <= 1'b0;
    end else begin
      event_tlast_unexpected <= in_hs && s_axis_data_tlast && (wcnt != LAST);
      event_tlast_missing    <= in_hs && !s_axis_data_tlast && (wcnt == LAST);
      if (close_bank) begin
        wcnt  <= '0;
        wbank <= ~wbank;
      end else if (in_hs) begin
        wcnt <= wcnt + L'(1);
      end else begin
        wcnt <= wcnt;
      end
    end
  end

  // Per-bank full flags: set when the writer closes a bank, cleared when the reader frees it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (close_bank && (wbank == 1'(b))) begin
          full[b] <= 1'b1;
        end else if (free_bank && (rbank == 1'(b))) begin
          full[b] <= 1'b0;
        end else begin
          full[b] <= full[b];
        end
      end
    end
  end

  // Read sequencer: waits for a full bank, streams its addresses, then drains the output.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rbank]) begin
            state <= STREAM;
            rcnt  <= '0;
          end
        end
        STREAM: begin
          if (room) begin
            rcnt <= rcnt + L'(1);
            if (rcnt == LAST) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (free_bank) begin
            rbank <= ~rbank;
            if (ren) begin
              state <= STREAM;
              rcnt  <= L'(1);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output skid buffer: the head drives the master port, the spare absorbs the RAM latency.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
      m_axis_data_tuser  <= '0;
      m_axis_data_tlast  <= 1'b0;
      sp_valid           <= 1'b0;
      sp_data            <= '0;
      sp_user            <= '0;
      sp_last            <= 1'b0;
    end else if (!m_axis_data_tvalid || pop) begin
      if (sp_valid) begin
        m_axis_data_tvalid <= 1'b1;
        m_axis_data_tdata  <= sp_data;
        m_axis_data_tuser  <= sp_user;
        m_axis_data_tlast  <= sp_last;
        sp_valid           <= ren;
        sp_data            <= rd_word;
        sp_user            <= rd_addr;
        sp_last            <= rd_last;
      end else begin
        m_axis_data_tvalid <= ren;
        if (ren) begin
          m_axis_data_tdata <= rd_word;
          m_axis_data_tuser <= rd_addr;
          m_axis_data_tlast <= rd_last;
        end
      end
    end else if (ren) begin
      sp_valid <= 1'b1;
      sp_data  <= rd_word;
      sp_user  <= rd_addr;
      sp_last  <= rd_last;
    end
  end

endmodule

// File: tb/tb_k_digitrev_sink.sv
// Testbench for k_digitrev_sink: random frames checked against a frame-level
// reference model (natural bin n takes the sample that arrived at position
// digitrev(n)), plus a small N=4 instance.
module tb_k_digitrev_sink;

  localparam int N  = 16;
  localparam int LW = 4;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [15:0] m_tdata;
  logic [3:0]  m_tuser;
  logic        m_tvalid, m_tready, m_tlast;
  logic        ev_u, ev_m;

  logic [15:0] s4_tdata;
  logic        s4_tvalid, s4_tlast, s4_tready;
  logic [15:0] m4_tdata;
  logic [1:0]  m4_tuser;
  logic        m4_tvalid, m4_tready, m4_tlast;
  logic        ev4_u, ev4_m;

  always #5 aclk = ~aclk;

  k_digitrev_sink #(.TRANSFORM_LENGTH(16), .DATA_WIDTH(16)) u_dut (
    .aclk(aclk), .areset(areset),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid),
    .s_axis_data_tready(s_tready), .s_axis_data_tlast(s_tlast),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tuser(m_tuser),
    .m_axis_data_tvalid(m_tvalid), .m_axis_data_tready(m_tready),
    .m_axis_data_tlast(m_tlast),
    .event_tlast_unexpected(ev_u), .event_tlast_missing(ev_m)
  );

  k_digitrev_sink #(.TRANSFORM_LENGTH(4), .DATA_WIDTH(16)) u_dut4 (
    .aclk(aclk), .areset(areset),
    .s_axis_data_tdata(s4_tdata), .s_axis_data_tvalid(s4_tvalid),
    .s_axis_data_tready(s4_tready), .s_axis_data_tlast(s4_tlast),
    .m_axis_data_tdata(m4_tdata), .m_axis_data_tuser(m4_tuser),
    .m_axis_data_tvalid(m4_tvalid), .m_axis_data_tready(m4_tready),
    .m_axis_data_tlast(m4_tlast),
    .event_tlast_unexpected(ev4_u), .event_tlast_missing(ev4_m)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference-model state.
  logic [15:0] fbuf [0:N-1];
  int          fk = 0;
  logic [15:0] exp_d [0:2047];
  int          exp_b [0:2047];
  int          out_cyc [0:2047];
  int          wr_i = 0;
  int          rd_i = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_stall = 0;
  bit          exp_u = 1'b0;
  bit          exp_m = 1'b0;
  time         hs_t = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Base-4 digit reversal by plain arithmetic.
  function automatic int rev4(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    for (int i = 0; i < LW / 2; i++) begin
      r = r * 4 + (x % 4);
      x = x / 4;
    end
    return r;
  endfunction

  // Record an accepted sample; on a complete frame queue its natural-order output.
  task automatic model_accept(input logic [15:0] d, input logic last);
    exp_u = last && (fk != N - 1);
    exp_m = !last && (fk == N - 1);
    hs_t  = $time;
    fbuf[fk] = d;
    fk++;
    n_acc++;
    if (fk == N) begin
      for (int n = 0; n < N; n++) begin
        exp_d[wr_i] = fbuf[rev4(n)];
        exp_b[wr_i] = n;
        wr_i++;
      end
      fk = 0;
    end
  endtask

  // Present one sample and wait (bounded) for its handshake.
  task automatic drive(input logic [15:0] d, input logic last, input bit gap);
    int budget;
    if (gap) begin
      s_tvalid = 1'b0;
      @(posedge aclk);
      #1;
    end
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    budget   = 0;
    forever begin
      @(negedge aclk);
      if (s_tready) break;
      n_stall++;
      budget++;
      if (budget > 400) begin
        check_val("in_timeout", 32'd0, 32'd1);
        s_tvalid = 1'b0;
        return;
      end
    end
    @(posedge aclk);
    model_accept(d, last);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (rd_i != wr_i && b < 1000) begin
      @(posedge aclk);
      b++;
    end
    check_val("drain_done", rd_i, wr_i);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Output and event monitor, sampled on the falling edge.
  always @(negedge aclk) begin
    if (areset) begin
      rd_i = wr_i;
    end else begin
      check_val("ev_unexp", ev_u, exp_u && ($time == hs_t + 5));
      check_val("ev_miss", ev_m, exp_m && ($time == hs_t + 5));
      if (m_tvalid) begin
        if (rd_i == wr_i) begin
          check_val("spurious_out", 32'd1, 32'd0);
        end else begin
          check_val("out_data", m_tdata, exp_d[rd_i]);
          check_val("out_bin", m_tuser, exp_b[rd_i]);
          check_val("out_last", m_tlast, exp_b[rd_i] == N - 1);
          if (m_tready) begin
            out_cyc[rd_i] = cyc;
            rd_i++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc0;
    int b;
    areset = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    s4_tvalid = 1'b0; s4_tdata = '0; s4_tlast = 1'b0; m4_tready = 1'b1;
    #3;
    check_val("rst_tready", s_tready, 1);
    check_val("rst_tvalid", m_tvalid, 0);
    check_val("rst_tlast", m_tlast, 0);
    check_val("rst_tuser", m_tuser, 0);
    check_val("rst_tdata", m_tdata, 0);
    check_val("rst_ev_u", ev_u, 0);
    check_val("rst_ev_m", ev_m, 0);
    repeat (2) @(posedge aclk);
    #3 areset = 1'b0;
    @(posedge aclk);
    #1;

    // Single frame with the digit-reversed ramp, plus latency check.
    for (int k = 0; k < N; k++) drive({8'h00, 8'(rev4(k))}, k == N - 1, 1'b0);
    @(negedge aclk); check_val("lat_e0", m_tvalid, 0);
    @(negedge aclk); check_val("lat_e1", m_tvalid, 0);
    @(negedge aclk); check_val("lat_e2", m_tvalid, 1);
    check_val("lat_bin0", m_tuser, 0);
    wait_drain();

    // Back-to-back frames, random data.
    base = wr_i;
    n_stall = 0;
    for (int k = 0; k < 3 * N; k++) begin
      drive(16'($urandom), (k % N) == N - 1, 1'b0);
      if (k == 2 * N - 1) check_val("b2b_no_stall", n_stall, 0);
    end
    wait_drain();
    for (int i = 0; i < 3 * N - 1; i++) begin
      if (i != 2 * N - 1) check_val("b2b_contig", out_cyc[base + i + 1] - out_cyc[base + i], 1);
    end

    // Backpressure: three frames against a stalled output, then random ready.
    m_tready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int k = 0; k < 3 * N; k++) drive(16'($urandom), (k % N) == N - 1, 1'b0);
      end
      begin
        repeat (60) @(posedge aclk);
        @(negedge aclk);
        check_val("bp_accepted", n_acc - acc0, 2 * N);
        check_val("bp_tready", s_tready, 0);
        check_val("bp_tvalid", m_tvalid, 1);
        check_val("bp_tuser", m_tuser, 0);
        b = 0;
        while (((n_acc - acc0) < 3 * N || rd_i != wr_i) && b < 4000) begin
          @(posedge aclk);
          #1 m_tready = 1'($urandom_range(0, 1));
          b++;
        end
        check_val("bp_all_in", n_acc - acc0, 3 * N);
        m_tready = 1'b1;
      end
    join
    wait_drain();

    // Framing errors: early tlast, then a missing tlast; random input gaps.
    for (int k = 0; k < N; k++)
      drive(16'($urandom), (k == 7) || (k == N - 1), $urandom_range(0, 3) == 0);
    for (int k = 0; k < N; k++)
      drive(16'($urandom), 1'b0, $urandom_range(0, 3) == 0);
    wait_drain();

    // Reset while frame 1 drains and frame 2 is 10 samples in.
    for (int k = 0; k < N + 10; k++) drive(16'($urandom), (k % N) == N - 1, 1'b0);
    #2 areset = 1'b1;
    fk = 0;
    #1;
    check_val("mrst_tvalid", m_tvalid, 0);
    check_val("mrst_tuser", m_tuser, 0);
    check_val("mrst_tdata", m_tdata, 0);
    check_val("mrst_tlast", m_tlast, 0);
    check_val("mrst_tready", s_tready, 1);
    repeat (2) @(posedge aclk);
    #3 areset = 1'b0;
    @(posedge aclk);
    #1;
    for (int k = 0; k < N; k++) drive(16'($urandom), k == N - 1, 1'b0);
    wait_drain();

    // Minimum size N=4: digit reversal is the identity.
    for (int k = 0; k < 4; k++) begin
      s4_tvalid = 1'b1;
      s4_tdata  = 16'(k);
      s4_tlast  = (k == 3);
      @(negedge aclk);
      check_val("n4_tready", s4_tready, 1);
      @(posedge aclk);
      #1;
    end
    s4_tvalid = 1'b0;
    b = 0;
    @(negedge aclk);
    while (!m4_tvalid && b < 20) begin
      @(negedge aclk);
      b++;
    end
    for (int i = 0; i < 4; i++) begin
      check_val("n4_valid", m4_tvalid, 1);
      check_val("n4_data", m4_tdata, i);
      check_val("n4_bin", m4_tuser, i);
      check_val("n4_last", m4_tlast, i == 3);
      check_val("n4_events", {ev4_u, ev4_m}, 0);
      @(negedge aclk);
    end
    check_val("n4_idle", m4_tvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
